// File: rtl/vga_display_arbiter_pkg.sv
// Shared definitions for the VGA display arbiter: source indices, FSM states,
// the black colour and the fixed-priority winner helper.
package vga_display_arbiter_pkg;

    localparam int N_SRC       = 3;
    localparam int SRC_WELCOME = 0;
    localparam int SRC_APP     = 1;
    localparam int SRC_TERM    = 2;

    typedef logic [23:0]      rgb_t;
    typedef logic [N_SRC-1:0] src_mask_t;

    localparam rgb_t RGB_BLACK = 24'h000000;

    localparam src_mask_t GNT_WELCOME = 3'b001 << SRC_WELCOME;
    localparam src_mask_t GNT_APP     = 3'b001 << SRC_APP;
    localparam src_mask_t GNT_TERM    = 3'b001 << SRC_TERM;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        SHOW,
        FADE_OUT
    } arb_state_t;

    // Isolates the lowest set bit, so a one-hot result with a smaller numeric
    // value always means a higher-priority source.
    function automatic src_mask_t pick_winner(input src_mask_t req);
        return req & (~req + 3'd1);
    endfunction

endpackage

// File: rtl/vga_display_arbiter_if.sv
// Bundle between the per-screen generators / VGA timing side and the arbiter.
interface vga_display_arbiter_if;
    import vga_display_arbiter_pkg::*;

    logic       frame_start;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    src_mask_t  req;
    rgb_t       rgb_welcome;
    rgb_t       rgb_app;
    rgb_t       rgb_term;
    src_mask_t  grant;
    logic       busy;
    rgb_t       rgb_out;

    modport slave (
        input  frame_start, h_addr, v_addr, req,
        input  rgb_welcome, rgb_app, rgb_term,
        output grant, busy, rgb_out
    );

    modport master (
        output frame_start, h_addr, v_addr, req,
        output rgb_welcome, rgb_app, rgb_term,
        input  grant, busy, rgb_out
    );

endinterface

// File: rtl/vga_display_arbiter_rgb_fader.sv
// Combinational brightness scaling: each 8-bit channel becomes
// (channel * level) >> FADE_SHIFT, so the top level passes the colour unchanged.
module vga_display_arbiter_rgb_fader
    import vga_display_arbiter_pkg::*;
#(
    parameter int FADE_SHIFT = 3
) (
    input  rgb_t              i_rgb,
    input  logic [FADE_SHIFT:0] i_level,
    output rgb_t              o_rgb
);

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [8+FADE_SHIFT:0] w_prod;

        assign w_prod = {{(FADE_SHIFT+1){1'b0}}, i_rgb[8*ch +: 8]} * {8'd0, i_level};
        assign o_rgb[8*ch +: 8] = w_prod[FADE_SHIFT +: 8];
    end

endmodule

// File: rtl/vga_display_arbiter.sv
// Fixed-priority owner of the VGA colour output; ownership changes only at
// frame boundaries through a frame-stepped fade-out / fade-in.
module vga_display_arbiter
    import vga_display_arbiter_pkg::*;
#(
    parameter int FADE_SHIFT = 3,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input logic                   clk,
    input logic                   rst,
    vga_display_arbiter_if.slave  bus
);

    localparam logic [FADE_SHIFT:0] LEVEL_ZERO = '0;
    localparam logic [FADE_SHIFT:0] LEVEL_ONE  = {{FADE_SHIFT{1'b0}}, 1'b1};
    localparam logic [FADE_SHIFT:0] LEVEL_MAX  = {1'b1, {FADE_SHIFT{1'b0}}};
    localparam logic [9:0]          H_LIM      = 10'(H_ACTIVE);
    localparam logic [9:0]          V_LIM      = 10'(V_ACTIVE);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    src_mask_t           r_grant;
    src_mask_t           w_grant_nxt;
    logic [FADE_SHIFT:0] r_level;
    logic [FADE_SHIFT:0] w_level_nxt;
    logic [FADE_SHIFT:0] w_level_inc;
    src_mask_t           w_winner;
    logic                w_owner_req;
    logic                w_preempt;
    rgb_t                w_src;
    rgb_t                w_faded;
    logic                w_visible;
    rgb_t                r_rgb_out;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_level <= LEVEL_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_level <= w_level_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_level_nxt = r_level;
        w_winner    = pick_winner(bus.req);
        w_owner_req = |(bus.req & r_grant);
        w_preempt   = (w_winner != '0) && (w_winner < r_grant);
        w_level_inc = r_level + LEVEL_ONE;

        if (bus.frame_start) begin
            case (r_state)
                IDLE: begin
                    if (w_winner != '0) begin
                        w_grant_nxt = w_winner;
                        w_level_nxt = LEVEL_ZERO;
                        w_state_nxt = FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (!w_owner_req || w_preempt) begin
                        w_state_nxt = FADE_OUT;
                    end else begin
                        w_level_nxt = w_level_inc;
                        if (w_level_inc == LEVEL_MAX) w_state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (!w_owner_req || w_preempt) w_state_nxt = FADE_OUT;
                end
                FADE_OUT: begin
                    // An owner dropped at level 0 is released on the next frame.
                    if (r_level <= LEVEL_ONE) begin
                        w_level_nxt = LEVEL_ZERO;
                        w_grant_nxt = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_level_nxt = r_level - LEVEL_ONE;
                    end
                end
                default: begin
                    w_level_nxt = LEVEL_ZERO;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (r_grant)
            GNT_WELCOME: w_src = bus.rgb_welcome;
            GNT_APP:     w_src = bus.rgb_app;
            GNT_TERM:    w_src = bus.rgb_term;
            default:     w_src = RGB_BLACK;
        endcase
    end

    vga_display_arbiter_rgb_fader #(
        .FADE_SHIFT (FADE_SHIFT)
    ) u_fader (
        .i_rgb   (w_src),
        .i_level (r_level),
        .o_rgb   (w_faded)
    );

    assign w_visible = (bus.h_addr < H_LIM) && (bus.v_addr < V_LIM);

    always_ff @(posedge clk) begin
        if (rst) r_rgb_out <= RGB_BLACK;
        else     r_rgb_out <= w_visible ? w_faded : RGB_BLACK;
    end

    assign bus.grant   = r_grant;
    assign bus.busy    = (r_state == FADE_IN) || (r_state == FADE_OUT);
    assign bus.rgb_out = r_rgb_out;

endmodule

// File: tb/tb_vga_display_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against an owner/level/leaving reference model.
module tb_vga_display_arbiter;
    import vga_display_arbiter_pkg::*;

    localparam int LVL_MAX = 8;
    localparam int GAP     = 16;

    logic clk = 1'b0;
    logic rst;
    vga_display_arbiter_if bus ();

    vga_display_arbiter #(
        .FADE_SHIFT (3),
        .H_ACTIVE   (640),
        .V_ACTIVE   (480)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_owner;
    int   m_level;
    bit   m_leaving;
    rgb_t m_rgb;
    logic [2:0] rnd_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_req(input logic [2:0] rq);
        for (int i = 0; i < 3; i++) if (rq[i]) return i;
        return 3;
    endfunction

    function automatic rgb_t src_colour(input int owner);
        case (owner)
            0:       return bus.rgb_welcome;
            1:       return bus.rgb_app;
            2:       return bus.rgb_term;
            default: return RGB_BLACK;
        endcase
    endfunction

    function automatic rgb_t scale(input rgb_t c, input int lvl, input int h, input int v);
        rgb_t r = RGB_BLACK;
        if (h < 640 && v < 480)
            for (int ch = 0; ch < 3; ch++)
                r[8*ch +: 8] = 8'((int'(c[8*ch +: 8]) * lvl) / 8);
        return r;
    endfunction

    function automatic logic [2:0] exp_grant();
        return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    endfunction

    function automatic logic exp_busy();
        return (m_owner >= 0) && (m_leaving || m_level < LVL_MAX);
    endfunction

    task automatic model_frame(input logic [2:0] rq);
        if (m_owner < 0) begin
            if (rq != 3'b000) begin
                m_owner   = lowest_req(rq);
                m_level   = 0;
                m_leaving = 0;
            end
        end else if (m_leaving) begin
            if (m_level <= 1) begin
                m_level   = 0;
                m_owner   = -1;
                m_leaving = 0;
            end else begin
                m_level--;
            end
        end else if (!rq[m_owner] || lowest_req(rq) < m_owner) begin
            m_leaving = 1;
        end else if (m_level < LVL_MAX) begin
            m_level++;
        end
    endtask

    task automatic cycle(input bit rs, input bit fs, input logic [2:0] rq);
        @(negedge clk);
        rst             = rs;
        bus.frame_start = fs;
        bus.req         = rq;
        if (rs) begin
            m_owner   = -1;
            m_level   = 0;
            m_leaving = 0;
            m_rgb     = RGB_BLACK;
        end else begin
            m_rgb = scale(src_colour(m_owner), m_level, int'(bus.h_addr), int'(bus.v_addr));
            if (fs) model_frame(rq);
        end
        @(posedge clk);
        #1;
        check("grant", bus.grant, exp_grant());
        check("busy", bus.busy, exp_busy());
        check("rgb_out", bus.rgb_out, m_rgb);
    endtask

    task automatic frame(input logic [2:0] rq, input int gap);
        cycle(1'b0, 1'b1, rq);
        repeat (gap - 1) cycle(1'b0, 1'b0, rq);
    endtask

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.req         = 3'b000;
        bus.h_addr      = 10'd0;
        bus.v_addr      = 10'd0;
        bus.rgb_welcome = RGB_BLACK;
        bus.rgb_app     = RGB_BLACK;
        bus.rgb_term    = RGB_BLACK;
        m_owner         = -1;
        m_level         = 0;
        m_leaving       = 0;
        m_rgb           = RGB_BLACK;
        rnd_req         = 3'b001;

        repeat (2) cycle(1'b1, 1'b0, 3'b000);
        check("rst_grant", bus.grant, 3'b000);
        check("rst_rgb", bus.rgb_out, 24'h000000);

        // Welcome fades in from black to full white over nine frames.
        bus.rgb_welcome = 24'hFFFFFF;
        for (int k = 1; k <= 9; k++) begin
            frame(3'b001, 800);
            check("fade_in_rgb", bus.rgb_out, {3{8'((255 * (k - 1)) / 8)}});
            check("fade_in_grant", bus.grant, 3'b001);
            check("fade_in_busy", bus.busy, (k < 9));
        end

        // Welcome drops: full fade-out, then application beats terminal.
        bus.rgb_app  = 24'h3366CC;
        bus.rgb_term = 24'hA0A0A0;
        frame(3'b110, GAP);
        check("drop_busy", bus.busy, 1'b1);
        repeat (7) frame(3'b110, GAP);
        check("fade_out_hold", bus.grant, 3'b001);
        frame(3'b110, GAP);
        check("fade_out_end", bus.grant, 3'b000);
        frame(3'b110, GAP);
        check("app_wins", bus.grant, 3'b010);

        // Terminal in SHOW is pre-empted by welcome.
        cycle(1'b1, 1'b0, 3'b000);
        bus.rgb_term = 24'h112233;
        repeat (9) frame(3'b100, GAP);
        check("term_show_busy", bus.busy, 1'b0);
        check("term_show_grant", bus.grant, 3'b100);
        frame(3'b101, GAP);
        check("preempt_busy", bus.busy, 1'b1);
        check("preempt_grant", bus.grant, 3'b100);
        repeat (8) frame(3'b101, GAP);
        check("preempt_release", bus.grant, 3'b000);
        frame(3'b101, GAP);
        check("welcome_wins", bus.grant, 3'b001);

        // Blanking boundaries with terminal fully shown.
        cycle(1'b1, 1'b0, 3'b000);
        bus.rgb_term = 24'h00C513;
        repeat (9) frame(3'b100, GAP);
        bus.h_addr = 10'd700; bus.v_addr = 10'd10;
        cycle(1'b0, 1'b0, 3'b100);
        check("blank_h", bus.rgb_out, 24'h000000);
        bus.h_addr = 10'd639;
        cycle(1'b0, 1'b0, 3'b100);
        check("edge_h", bus.rgb_out, 24'h00C513);
        bus.h_addr = 10'd0; bus.v_addr = 10'd480;
        cycle(1'b0, 1'b0, 3'b100);
        check("blank_v", bus.rgb_out, 24'h000000);
        bus.v_addr = 10'd479;
        cycle(1'b0, 1'b0, 3'b100);
        check("edge_v", bus.rgb_out, 24'h00C513);

        // Reset in the middle of a fade-in at level 4.
        cycle(1'b1, 1'b0, 3'b000);
        bus.v_addr = 10'd0;
        repeat (5) frame(3'b001, GAP);
        check("mid_fade_busy", bus.busy, 1'b1);
        cycle(1'b1, 1'b0, 3'b001);
        check("rst_fade_grant", bus.grant, 3'b000);
        check("rst_fade_busy", bus.busy, 1'b0);
        check("rst_fade_rgb", bus.rgb_out, 24'h000000);
        repeat (GAP) cycle(1'b0, 1'b0, 3'b001);
        check("no_frame_idle", bus.grant, 3'b000);
        frame(3'b001, GAP);
        check("recover_grant", bus.grant, 3'b001);

        // A request pulse between frame boundaries is invisible.
        cycle(1'b1, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 3'b000);
        repeat (3) cycle(1'b0, 1'b0, 3'b000);
        repeat (4) cycle(1'b0, 1'b0, 3'b001);
        repeat (3) cycle(1'b0, 1'b0, 3'b000);
        cycle(1'b0, 1'b1, 3'b000);
        check("pulse_grant", bus.grant, 3'b000);
        check("pulse_busy", bus.busy, 1'b0);

        // Random traffic against the reference model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 39) == 0) rnd_req = 3'($urandom_range(0, 7));
            bus.rgb_welcome = 24'($urandom);
            bus.rgb_app     = 24'($urandom);
            bus.rgb_term    = 24'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.h_addr = 10'($urandom_range(0, 1023));
                1:       bus.h_addr = 10'($urandom_range(638, 641));
                default: bus.h_addr = 10'($urandom_range(0, 639));
            endcase
            case ($urandom_range(0, 3))
                0:       bus.v_addr = 10'($urandom_range(0, 1023));
                1:       bus.v_addr = 10'($urandom_range(478, 481));
                default: bus.v_addr = 10'($urandom_range(0, 479));
            endcase
            cycle(($urandom_range(0, 1999) == 0), ($urandom_range(0, 7) == 0), rnd_req);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_display_arbiter.md
Name: vga_display_arbiter

Overview:
- Shares the single VGA RGB output between three screen sources: welcome animation, application/game, and text terminal.
- Grants the screen to one requester at a time by fixed priority.
- Switches owners only on frame boundaries, with a frame-stepped fade-out/fade-in so hand-over never tears mid-frame.
- Sits between the per-screen rgb generators and the VGA timing module; the welcome block's inWelcome drives req[0].

Parameters:
- FADE_SHIFT, 3: fade length is 2^FADE_SHIFT frames; brightness level range is 0..2^FADE_SHIFT.
- H_ACTIVE, 640: visible width; h_addr >= H_ACTIVE forces black.
- V_ACTIVE, 480: visible height; v_addr >= V_ACTIVE forces black.

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse per frame, issued in vertical blanking
- h_addr  in  10  current pixel column from VGA controller
- v_addr  in  10  current pixel row from VGA controller
- req  in  3  screen requests; bit0 welcome (highest), bit1 application, bit2 terminal (lowest)
- rgb_welcome  in  24  welcome source colour
- rgb_app  in  24  application source colour
- rgb_term  in  24  terminal source colour
- grant  out  3  one-hot current owner; 0 when none
- busy  out  1  high in FADE_IN/FADE_OUT
- rgb_out  out  24  arbitrated, faded colour to VGA

Behaviour:
- Reset, synchronous and active-high, applies on any clk edge, including mid-fade:
  - state=IDLE, grant=0, level=0, pending=0, busy=0, rgb_out=0.
- winner = lowest-index set bit of req; none if req==0.
- All state and level changes occur only on cycles with frame_start=1. req is sampled only on those cycles.
- IDLE: on frame_start with req!=0: grant<=winner, level<=0, go FADE_IN. Otherwise stay IDLE.
- FADE_IN, on frame_start:
  - If owner's req bit is clear, or winner has higher priority than owner: go FADE_OUT. level is unchanged that frame.
  - Else level<=level+1; when the new level equals 2^FADE_SHIFT, go SHOW.
- SHOW, on frame_start: if owner's req is clear, or a higher-priority req is set, go FADE_OUT. Otherwise hold.
- FADE_OUT, on frame_start:
  - level<=level-1.
  - When level reaches 0, grant<=0 for that step. The next frame_start then behaves as IDLE: a new winner is granted from that cycle's req, or the block stays IDLE.
  - Owner re-asserting req during FADE_OUT does not abort the fade.
- busy = (state==FADE_IN || state==FADE_OUT).
- Colour path:
  - src = rgb of the granted source, or 0 if grant==0.
  - Each 8-bit channel: (ch * level) >> FADE_SHIFT. The product is 12 bits wide; truncate the result to 8 bits. At level=2^FADE_SHIFT the output equals the input exactly.
  - If h_addr >= H_ACTIVE or v_addr >= V_ACTIVE, the channel value is 0.
  - rgb_out is registered: 1-cycle latency from h_addr/v_addr/rgb_* to rgb_out.
- Simultaneous events: a frame_start coincident with a req change uses the req value of that same cycle.
- Requests deasserting and reasserting between frame_starts are invisible.

Decomposition:
- Shared package holds:
  - source index constants SRC_WELCOME=0, SRC_APP=1, SRC_TERM=2;
  - state encoding IDLE/FADE_IN/SHOW/FADE_OUT;
  - the 24'h000000 black constant.
- One natural sub-module: rgb_fader. It is combinational per-channel scaling, with inputs rgb and level and output rgb. It is instantiated once, ahead of the output register.

Test Plan:
- Reset, then req=3'b001 with frame_start every 800 cycles, rgb_welcome=24'hFFFFFF at pixel (0,0):
  - grant=001 after the 1st frame_start;
  - rgb_out = 0,1F,3F,...,DF, then FFFFFF across frames 1..9;
  - busy falls on entering SHOW.
- In SHOW with owner welcome, set req=3'b110 (welcome drops):
  - 8 frames of FADE_OUT down to level 0, then grant=0;
  - the next frame_start gives grant=010 (application beats terminal), then FADE_IN.
- In SHOW with owner terminal (req=100), assert req=101:
  - FADE_OUT starts at the next frame_start;
  - after fade-out completes, grant=001.
- h_addr=700, v_addr=10 with owner in SHOW and rgb=24'h00C513: rgb_out=0 one cycle later; h_addr=639 gives 00C513.
- Assert rst during FADE_IN at level 4: next cycle grant=0, rgb_out=0, busy=0, state IDLE. Recovery needs a fresh frame_start.
- req toggles 000→001→000 entirely between two frame_starts: no grant change, state stays IDLE.
